bnn_seq_classifier: RTL and testbench

- Parametrised, time-multiplexed binary neural network classifier core. Successor to the fixed-size serial BNN classifiers.
- Accepts one packed feature vector per transaction through a valid/ready handshake. Evaluates one hidden neuron per cycle, then one class neuron per cycle with a running argmax.
- Presents the prediction and its score, and holds them under output backpressure. Sits between the feature source (testbench or sensor front end) and the result consumer.

---
 rtl/bnn_pkg.sv | 42 ++++
 rtl/bnn_xnor_popcount.sv | 31 +++
 rtl/bnn_seq_classifier.sv | 157 +++++++++++++++
 tb/tb_bnn_seq_classifier.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_pkg
//  Description : Shared widths, FSM state encoding and popcount helper for
//                the time-multiplexed binary neural network classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

   // Default network geometry; the core itself is parametrised and derives
   // its own widths, these describe the default build.
   localparam int DEF_FEAT_CNT   = 19;
   localparam int DEF_FEAT_BITS  = 4;
   localparam int DEF_HIDDEN_CNT = 40;
   localparam int DEF_CLASS_CNT  = 3;

   localparam int IN_BITS  = DEF_FEAT_CNT * DEF_FEAT_BITS;
   localparam int SUM_BITS = $clog2(DEF_HIDDEN_CNT + 1);
   localparam int IDX_BITS = $clog2(DEF_CLASS_CNT);

   // Widest vector the popcount helper handles; callers zero-extend into it.
   localparam int POP_MAX  = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HID  = 2'd1,
      CLS  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Number of set bits in v.
   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_xnor_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_xnor_popcount
//  Description : Combinational binary dot product: counts positions where
//                a and b agree, i.e. popcount(~(a ^ b)).
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_popcount
   import bnn_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   output logic [$clog2(WIDTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [POP_MAX-1:0] w_ext;

   // Agreement vector zero-extended into the helper's fixed width; the
   // padding contributes nothing to the count.
   always_comb begin
      w_ext              = '0;
      w_ext[WIDTH-1:0]   = ~(a ^ b);
      count              = CNT_W'(popcount(w_ext));
   end

endmodule
`default_nettype wire

// File: rtl/bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : bnn_seq_classifier
//  Description : Time-multiplexed BNN classifier. One hidden neuron per cycle,
//                then one class neuron per cycle with a running argmax.
//                Result is held under output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module bnn_seq_classifier
   import bnn_pkg::*;
#(
   parameter int FEAT_CNT   = DEF_FEAT_CNT,
   parameter int FEAT_BITS  = DEF_FEAT_BITS,
   parameter int HIDDEN_CNT = DEF_HIDDEN_CNT,
   parameter int CLASS_CNT  = DEF_CLASS_CNT,
   parameter logic [HIDDEN_CNT*FEAT_CNT*FEAT_BITS-1:0] W1 = '0,
   parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]          W2 = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [FEAT_CNT*FEAT_BITS-1:0]      features,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [$clog2(CLASS_CNT)-1:0]       prediction,
   output logic [$clog2(HIDDEN_CNT+1)-1:0]    max_score,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               busy
);

   localparam int IN_W   = FEAT_CNT * FEAT_BITS;
   localparam int HPC_W  = $clog2(IN_W + 1);
   localparam int CPC_W  = $clog2(HIDDEN_CNT + 1);
   localparam int PRED_W = $clog2(CLASS_CNT);
   localparam int MAX_N  = (HIDDEN_CNT > CLASS_CNT) ? HIDDEN_CNT : CLASS_CNT;
   localparam int CNT_W  = $clog2(MAX_N);

   state_t              r_state;
   logic [IN_W-1:0]     r_x;
   logic [HIDDEN_CNT-1:0] r_h;
   logic [CNT_W-1:0]    r_cnt;
   logic [CPC_W-1:0]    r_best_score;
   logic [PRED_W-1:0]   r_best_idx;

   logic [IN_W-1:0]       w_w1_row;
   logic [HIDDEN_CNT-1:0] w_w2_row;
   logic [HPC_W-1:0]      w_hpc;
   logic [CPC_W-1:0]      w_cpc;
   logic [HPC_W:0]        w_pc2;
   logic                  w_hbit;
   logic                  w_take;
   logic [CPC_W-1:0]      w_fin_score;
   logic [PRED_W-1:0]     w_fin_idx;

   // Weight row selection by counter; rows past the end select zero, which
   // only happens for the matrix not in use in the current phase.
   always_comb begin
      w_w1_row = '0;
      w_w2_row = '0;
      for (int j = 0; j < HIDDEN_CNT; j++) begin
         if (r_cnt == CNT_W'(j)) w_w1_row = W1[j*IN_W +: IN_W];
      end
      for (int c = 0; c < CLASS_CNT; c++) begin
         if (r_cnt == CNT_W'(c)) w_w2_row = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
      end
   end

   bnn_xnor_popcount #(.WIDTH(IN_W)) u_hid_pop (
      .a     (r_x),
      .b     (w_w1_row),
      .count (w_hpc)
   );

   bnn_xnor_popcount #(.WIDTH(HIDDEN_CNT)) u_cls_pop (
      .a     (r_h),
      .b     (w_w2_row),
      .count (w_cpc)
   );

   // Neuron activation and argmax update; 2*pc keeps one extra bit so the
   // threshold compare never wraps. Strict greater-than keeps the lower index
   // on ties, and class 0 always seeds the running best.
   always_comb begin
      w_pc2       = {w_hpc, 1'b0};
      w_hbit      = (w_pc2 >= (HPC_W+1)'(IN_W));
      w_take      = (r_cnt == '0) || (w_cpc > r_best_score);
      w_fin_score = w_take ? w_cpc : r_best_score;
      w_fin_idx   = w_take ? r_cnt[PRED_W-1:0] : r_best_idx;
   end

   // Control FSM with registered handshake outputs and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_x          <= '0;
         r_h          <= '0;
         r_cnt        <= '0;
         r_best_score <= '0;
         r_best_idx   <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         prediction   <= '0;
         max_score    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r_x      <= features;
                  r_h      <= '0;
                  r_cnt    <= '0;
                  r_state  <= HID;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            HID: begin
               for (int j = 0; j < HIDDEN_CNT; j++) begin
                  if (r_cnt == CNT_W'(j)) r_h[j] <= w_hbit;
               end
               if (r_cnt == CNT_W'(HIDDEN_CNT-1)) begin
                  r_cnt   <= '0;
                  r_state <= CLS;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            CLS: begin
               r_best_score <= w_fin_score;
               r_best_idx   <= w_fin_idx;
               if (r_cnt == CNT_W'(CLASS_CNT-1)) begin
                  r_cnt      <= '0;
                  r_state    <= DONE;
                  busy       <= 1'b0;
                  out_valid  <= 1'b1;
                  prediction <= w_fin_idx;
                  max_score  <= w_fin_score;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bnn_seq_classifier
//  Description : Self-checking bench for bnn_seq_classifier in the small
//                2x2-feature / 2-hidden / 3-class configuration. A second
//                instance with tied class rows shares all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_seq_classifier;

   localparam int HC = 2;
   localparam int CC = 3;
   localparam logic [7:0] P_W1  = 8'b0000_1111;     // row0=1111 row1=0000
   localparam logic [5:0] P_W2  = 6'b11_10_01;      // c0=01 c1=10 c2=11
   localparam logic [5:0] P_W2T = 6'b11_01_01;      // c0=01 c1=01 c2=11

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] features = 4'd0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready, out_valid, busy;
   logic [1:0] prediction, max_score;
   logic       t_in_ready, t_out_valid, t_busy;
   logic [1:0] t_prediction, t_max_score;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] feat;
      int         pred;
      int         score;
   } vec_t;

   vec_t vecs[5];

   bnn_seq_classifier #(
      .FEAT_CNT(2), .FEAT_BITS(2), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
      .W1(P_W1), .W2(P_W2)
   ) u_dut (
      .clk(clk), .rst(rst), .features(features), .in_valid(in_valid),
      .in_ready(in_ready), .prediction(prediction), .max_score(max_score),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   bnn_seq_classifier #(
      .FEAT_CNT(2), .FEAT_BITS(2), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
      .W1(P_W1), .W2(P_W2T)
   ) u_dut_tie (
      .clk(clk), .rst(rst), .features(features), .in_valid(in_valid),
      .in_ready(t_in_ready), .prediction(t_prediction), .max_score(t_max_score),
      .out_valid(t_out_valid), .out_ready(out_ready), .busy(t_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: hidden neuron fires when at least half the input bits match
   // its weight row; class score counts hidden bits matching the class row;
   // the first class reaching the highest score wins.
   function automatic void model(input logic [3:0] f, input logic [5:0] w2,
                                 output int pred, output int score);
      logic [7:0] w1;
      logic [5:0] w2v;
      int hb[HC];
      int m, s;
      w1  = P_W1;
      w2v = w2;
      for (int j = 0; j < HC; j++) begin
         m = 0;
         for (int b = 0; b < 4; b++) if (f[b] == w1[j*4+b]) m++;
         hb[j] = (2*m >= 4) ? 1 : 0;
      end
      score = -1;
      pred  = 0;
      for (int c = 0; c < CC; c++) begin
         s = 0;
         for (int j = 0; j < HC; j++) if (hb[j] == int'(w2v[c*HC+j])) s++;
         if (s > score) begin
            score = s;
            pred  = c;
         end
      end
   endfunction

   task automatic check_outputs(input string tag, input logic [3:0] f);
      int ep, es, tp, ts;
      model(f, P_W2, ep, es);
      model(f, P_W2T, tp, ts);
      check({tag, "_pred"}, int'(prediction), ep);
      check({tag, "_score"}, int'(max_score), es);
      check({tag, "_tie_pred"}, int'(t_prediction), tp);
      check({tag, "_tie_score"}, int'(t_max_score), ts);
   endtask

   // One transaction: accept, wait for the result, hold it for hold_cyc
   // cycles (with a rejected in_valid pulse), then release.
   task automatic run_txn(input string tag, input logic [3:0] f, input int hold_cyc,
                          output int p, output int s);
      int lat;
      check({tag, "_in_ready_idle"}, int'(in_ready), 1);
      features = f;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      features = ~f;
      check({tag, "_busy"}, int'(busy), 1);
      // accept edge counts as edge 1
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_out_valid"}, int'(out_valid), 1);
      check({tag, "_tie_out_valid"}, int'(t_out_valid), 1);
      check({tag, "_latency"}, lat, HC + CC + 1);
      check_outputs(tag, f);
      p = int'(prediction);
      s = int'(max_score);
      for (int k = 0; k < hold_cyc; k++) begin
         if (k == 2) begin
            in_valid = 1'b1;
            features = ~f;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({tag, "_hold_valid"}, int'(out_valid), 1);
         check({tag, "_hold_in_ready"}, int'(in_ready), 0);
         check_outputs({tag, "_hold"}, f);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, int'(out_valid), 0);
      check({tag, "_rel_in_ready"}, int'(in_ready), 1);
      check({tag, "_rel_busy"}, int'(busy), 0);
      check_outputs({tag, "_rel"}, f);
   endtask

   initial begin
      int p, s;
      int acc[$];
      logic ir;
      logic [3:0] rf;
      int n;

      vecs[0] = '{feat: 4'b1111, pred: 0, score: 2};
      vecs[1] = '{feat: 4'b0000, pred: 1, score: 2};
      vecs[2] = '{feat: 4'b0011, pred: 2, score: 2};
      vecs[3] = '{feat: 4'b1100, pred: 2, score: 2};
      vecs[4] = '{feat: 4'b0001, pred: 1, score: 2};

      // reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_pred", int'(prediction), 0);
      check("rst_score", int'(max_score), 0);
      check("rst_tie_in_ready", int'(t_in_ready), 1);
      rst = 1'b1;
      @(posedge clk); #1;

      // table vectors
      for (int i = 0; i < 5; i++) begin
         run_txn("vec", vecs[i].feat, 0, p, s);
         check("vec_tbl_pred", p, vecs[i].pred);
         check("vec_tbl_score", s, vecs[i].score);
      end

      // tie: lower index wins on the tied instance
      run_txn("tie", 4'b1111, 0, p, s);
      check("tie_pred_low", int'(t_prediction), 0);
      check("tie_score", int'(t_max_score), 2);

      // backpressure for 10 cycles with a rejected pulse
      run_txn("bp", 4'b0011, 10, p, s);

      // back-to-back with in_valid and out_ready held high
      features  = 4'b1111;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         ir = in_ready;
         @(posedge clk); #1;
         if (ir) acc.push_back(k);
         if (out_valid) begin
            check("b2b_pred", int'(prediction), 0);
            check("b2b_score", int'(max_score), 2);
         end
      end
      in_valid = 1'b0;
      check("b2b_accepts", acc.size(), 3);
      if (acc.size() >= 3) begin
         check("b2b_spacing0", acc[1] - acc[0], HC + CC + 2);
         check("b2b_spacing1", acc[2] - acc[1], HC + CC + 2);
      end
      n = 0;
      while (!(in_ready && !busy && !out_valid) && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      check("b2b_drained", int'(in_ready && !busy && !out_valid), 1);

      // reset mid-operation
      run_txn("pre_rst", 4'b0011, 0, p, s);
      features = 4'b1111;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("mrst_busy", int'(busy), 0);
      check("mrst_in_ready", int'(in_ready), 1);
      check("mrst_out_valid", int'(out_valid), 0);
      check("mrst_pred", int'(prediction), 0);
      check("mrst_score", int'(max_score), 0);
      run_txn("post_rst", 4'b0000, 0, p, s);

      // randomized transactions against the model
      for (int i = 0; i < 25; i++) begin
         rf = 4'($urandom);
         run_txn("rand", rf, int'($urandom_range(0, 3)), p, s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
